mem_responder: RTL

- Target side of the read/write/ack memory handshake; the initiator drives `read`/`write`/`addr`/`data_i` and waits for `ack`.
- Holds a DEPTH x DATA_W register array.
- Completes each request after a fixed wait latency; a request withdrawn before completion is cancelled with no side effect.
- Sits behind the bench or any master using this interface.

---
 rtl/mem_responder.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder: read/write/ack memory target, DEPTH x DATA_W words, fixed completion latency.
// Optional MEM_RW_CONFLICT_ERR_EN adds an err output and rejects simultaneous read+write.
module mem_responder #(
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
`ifdef MEM_RW_CONFLICT_ERR_EN
    output logic              err,
`endif
    output logic              ack
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                op_wr_q, op_wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic accept;
    logic op_line;
    logic commit;

`ifdef MEM_RW_CONFLICT_ERR_EN
    logic conflict;
    logic err_q, err_d;

    always_comb begin
        conflict = read & write;
        accept   = (read | write) & ~conflict;
        err_d    = conflict & (state_q != BUSY);
    end
`else
    // Without conflict checking, read+write falls through as a write.
    always_comb begin
        accept = read | write;
    end
`endif

    always_comb begin
        op_line = op_wr_q ? write : read;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE, ACK: begin
                state_d = IDLE;
                if (accept) begin
                    op_wr_d = write;
                    addr_d  = addr;
                    wdata_d = data_i;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // A single-cycle latency leaves no window to cancel.
                if ((LATENCY > 1) && !op_line) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        commit = (state_q == BUSY) && (state_d == ACK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (commit && op_wr_q) begin
            mem_q[addr_q] <= wdata_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (commit && !op_wr_q) begin
            rdata_q <= mem_q[addr_q];
        end
    end

`ifdef MEM_RW_CONFLICT_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    always_comb begin
        err = err_q;
    end
`endif

    always_comb begin
        ack    = (state_q == ACK);
        data_o = rdata_q;
    end

endmodule
